instr_stream_loader: RTL and testbench
======================================

# instr_stream_loader

Front-end loader sitting directly upstream of the single-cycle RISC-I `CPU` core and its instruction memory. It consumes the one-word-per-cycle instruction stream on the CPU's instruction-write input and frames the program with reserved start/end marker words. It writes each program word into instruction memory at consecutive addresses and holds the core in reset until the complete program is loaded. It also reports the loaded instruction count and an overflow error.

## Interface
- `WORD_LEN`, 32, instruction/data word width.
- `InstrMEM_SIZE`, 64, instruction memory depth in words; address width is `$clog2(InstrMEM_SIZE)`.
- `START_WORD`, 32'h0000_00FE, reserved start-of-program marker.
- `END_WORD`, 32'h0000_00FF, reserved end-of-program marker.

Ports:
- `i_CLK`  in  1  single clock; all state updates on its rising edge.
- `i_RSTN`  in  1  reset, asynchronous and active-low.
- `i_Write_Instr`  in  WORD_LEN  stream word; sampled on every rising edge, with no valid qualifier.
- `o_IMEM_WE`  out  1  instruction memory write enable.
- `o_IMEM_Addr`  out  $clog2(InstrMEM_SIZE)  write address.
- `o_IMEM_Data`  out  WORD_LEN  write data.
- `o_Core_RSTN`  out  1  active-low reset to the CPU core; low while loading.
- `o_Load_Done`  out  1  high while in RUN.
- `o_Instr_Count`  out  $clog2(InstrMEM_SIZE)+1  number of words written for the current program.
- `o_Overflow`  out  1  sticky error: the program exceeded memory depth.

## Operation
States are IDLE, LOAD, RUN and ERR.
- Reset values: state=IDLE, o_IMEM_WE=0, o_IMEM_Addr=0, o_IMEM_Data=0, o_Core_RSTN=0, o_Load_Done=0, o_Instr_Count=0, o_Overflow=0.
- IDLE:
  - START_WORD → LOAD, with the count cleared to 0.
  - All other words, including END_WORD and 0, are ignored.
- LOAD, for a sampled word w:
  - w==START_WORD: restart. Count is cleared to 0, no write is issued, and the state stays LOAD.
  - w==END_WORD: → RUN.
  - Otherwise, if count < InstrMEM_SIZE: issue a write with addr=count and data=w, then count=count+1. Zero words are legal instructions and are written.
  - Otherwise (count == InstrMEM_SIZE): → ERR with no write, and o_Overflow=1.
- RUN: o_Core_RSTN=1 and o_Load_Done=1.
  - START_WORD → LOAD. Count is cleared, o_Core_RSTN=0 and o_Load_Done=0 in the same update.
  - All other words are ignored and the count is held.
- ERR: o_Core_RSTN=0 and o_Overflow=1. All input is ignored; only i_RSTN exits this state.
- Empty program (START_WORD then END_WORD): → RUN with count 0; the core is released on stale memory contents (accepted behaviour).
- Count width: count saturates logically at InstrMEM_SIZE; it never wraps. o_IMEM_Addr is the low bits of count, and no address ≥ InstrMEM_SIZE is ever driven with WE=1.

## Timing
- All outputs are registered from state/count; there is no combinational path from i_Write_Instr to any output.
- Write latency:
  - A word sampled at edge k drives o_IMEM_WE=1 with its addr/data during cycle k→k+1.
  - Memory captures it at edge k+1.
  - o_IMEM_WE=1 for exactly one cycle per accepted word.
- Back-to-back words produce WE=1 on consecutive cycles with addresses incrementing by 1.
- o_Instr_Count updates at the same edge as the corresponding WE assertion.
- END_WORD sampled at edge k:
  - o_Core_RSTN and o_Load_Done rise after edge k.
  - The last program word (sampled at k-1) is written at edge k, so memory is complete before the core sees its first edge with reset released (edge k+1).
- START_WORD sampled in RUN at edge k: o_Core_RSTN falls after edge k.
- Asynchronous reset asserted mid-LOAD or mid-RUN: all outputs return to their reset values immediately, without waiting for a clock edge. Memory contents are not cleared.
- Reset deassertion: the first word sampled is at the first rising edge with i_RSTN=1.

## Test plan
- Reset then stream FE, 0x11, 0x22, 0x00, 0x33, FF:
  - Writes (0,0x11), (1,0x22), (2,0x00), (3,0x33) land on consecutive edges.
  - o_Instr_Count=4, and o_Core_RSTN/o_Load_Done rise one cycle after FF is sampled.
- Words 0x55, FF, then 0 before any FE: no WE pulse, state stays IDLE, o_Core_RSTN=0.
- FE followed by 65 non-marker words (InstrMEM_SIZE=64):
  - 64 writes at addresses 0..63.
  - The 65th word causes no write, and o_Overflow=1.
  - A later FF leaves o_Core_RSTN=0 until i_RSTN pulses low.
- In RUN, send FE, 0xAA, FF:
  - o_Core_RSTN drops after FE.
  - 0xAA is written at addr 0 and the count becomes 1.
  - o_Core_RSTN rises again after FF.
- FE, 0x11, 0x22, FE, 0x99, FF: the restart rewrites addr 0 with 0x99, and the final o_Instr_Count=1.
- Assert i_RSTN=0 mid-cycle during LOAD after 3 words:
  - All outputs go to reset values before the next edge.
  - On release, 0x44 followed by FF is ignored (IDLE).

Source files
------------

// File: rtl/instr_stream_loader_if.sv
// Instruction stream in, instruction-memory write bus and core control out.
// The loader drives everything except the stream word, hence it takes the master side.
interface instr_stream_loader_if #(
    parameter int WORD_LEN      = 32,
    parameter int InstrMEM_SIZE = 64
);
    localparam int ADDR_W = $clog2(InstrMEM_SIZE);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WORD_LEN-1:0] i_Write_Instr;
    logic                o_IMEM_WE;
    logic [ADDR_W-1:0]   o_IMEM_Addr;
    logic [WORD_LEN-1:0] o_IMEM_Data;
    logic                o_Core_RSTN;
    logic                o_Load_Done;
    logic [CNT_W-1:0]    o_Instr_Count;
    logic                o_Overflow;

    modport master (
        input  i_Write_Instr,
        output o_IMEM_WE,
        output o_IMEM_Addr,
        output o_IMEM_Data,
        output o_Core_RSTN,
        output o_Load_Done,
        output o_Instr_Count,
        output o_Overflow
    );

    modport slave (
        output i_Write_Instr,
        input  o_IMEM_WE,
        input  o_IMEM_Addr,
        input  o_IMEM_Data,
        input  o_Core_RSTN,
        input  o_Load_Done,
        input  o_Instr_Count,
        input  o_Overflow
    );
endinterface

// File: rtl/instr_stream_loader.sv
// Frames a START/END-delimited instruction stream, writes it into instruction memory
// and holds the CPU core in reset until the whole program has landed.
module instr_stream_loader #(
    parameter int                WORD_LEN      = 32,
    parameter int                InstrMEM_SIZE = 64,
    parameter logic [WORD_LEN-1:0] START_WORD  = 32'h0000_00FE,
    parameter logic [WORD_LEN-1:0] END_WORD    = 32'h0000_00FF
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTN,
    instr_stream_loader_if.master bus
);
    localparam int ADDR_W = $clog2(InstrMEM_SIZE);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MEM_DEPTH = CNT_W'(InstrMEM_SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]          state_reg,    state_next;
    logic [CNT_W-1:0]    count_reg,    count_next;
    logic                we_reg,       we_next;
    logic [ADDR_W-1:0]   addr_reg,     addr_next;
    logic [WORD_LEN-1:0] data_reg,     data_next;
    logic                core_rstn_reg, core_rstn_next;
    logic                done_reg,     done_next;
    logic                overflow_reg, overflow_next;

    logic is_start;
    logic is_end;
    logic has_room;

    assign is_start = (bus.i_Write_Instr == START_WORD);
    assign is_end   = (bus.i_Write_Instr == END_WORD);
    assign has_room = (count_reg < MEM_DEPTH);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (is_start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                end
            end
            ST_LOAD: begin
                if (is_start) begin
                    count_next = '0;
                end else if (is_end) begin
                    state_next = ST_RUN;
                end else if (has_room) begin
                    we_next    = 1'b1;
                    addr_next  = count_reg[ADDR_W-1:0];
                    data_next  = bus.i_Write_Instr;
                    count_next = count_reg + CNT_W'(1);
                end else begin
                    // Program longer than memory: refuse the word and park until reset.
                    state_next = ST_ERR;
                end
            end
            ST_RUN: begin
                if (is_start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they change on the same edge as the state.
    always_comb begin
        core_rstn_next = (state_next == ST_RUN);
        done_next      = (state_next == ST_RUN);
        overflow_next  = overflow_reg | (state_next == ST_ERR);
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            core_rstn_reg <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            core_rstn_reg <= core_rstn_next;
            done_reg      <= done_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign bus.o_IMEM_WE     = we_reg;
    assign bus.o_IMEM_Addr   = addr_reg;
    assign bus.o_IMEM_Data   = data_reg;
    assign bus.o_Core_RSTN   = core_rstn_reg;
    assign bus.o_Load_Done   = done_reg;
    assign bus.o_Instr_Count = count_reg;
    assign bus.o_Overflow    = overflow_reg;
endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized and directed bench for instr_stream_loader against a word-by-word
// behavioural model of the loader protocol and a shadow of instruction memory.
module tb_instr_stream_loader;
    localparam int WL    = 32;
    localparam int DEPTH = 64;
    localparam logic [31:0] SW = 32'h0000_00FE;
    localparam logic [31:0] EW = 32'h0000_00FF;

    logic clk;
    logic rst_n;

    instr_stream_loader_if #(.WORD_LEN(WL), .InstrMEM_SIZE(DEPTH)) bus ();

    instr_stream_loader #(
        .WORD_LEN(WL), .InstrMEM_SIZE(DEPTH), .START_WORD(SW), .END_WORD(EW)
    ) dut (
        .i_CLK (clk),
        .i_RSTN(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Behavioural model: mode 0=idle 1=loading 2=running 3=error
    int          m_mode;
    int          m_count;
    bit          m_ovf;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;
    logic [31:0] model_mem [DEPTH];
    bit          model_written [DEPTH];
    logic [31:0] shadow_mem [DEPTH];

    always @(posedge clk)
        if (bus.o_IMEM_WE) shadow_mem[bus.o_IMEM_Addr] <= bus.o_IMEM_Data;

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed !== expected)
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        else
            checks_passed++;
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_ovf = 0; m_we = 0;
    endtask

    task automatic model_step(input logic [31:0] w);
        m_we = 0;
        case (m_mode)
            0: if (w == SW) begin m_mode = 1; m_count = 0; end
            1: begin
                if (w == SW) m_count = 0;
                else if (w == EW) m_mode = 2;
                else if (m_count < DEPTH) begin
                    m_we = 1; m_addr = m_count; m_data = w;
                    model_mem[m_count] = w; model_written[m_count] = 1;
                    m_count++;
                end else begin
                    m_mode = 3; m_ovf = 1;
                end
            end
            2: if (w == SW) begin m_mode = 1; m_count = 0; end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string ctx);
        check_val({ctx, ":we"}, 64'(bus.o_IMEM_WE), 64'(m_we));
        if (m_we) begin
            check_val({ctx, ":addr"}, 64'(bus.o_IMEM_Addr), 64'(m_addr));
            check_val({ctx, ":data"}, 64'(bus.o_IMEM_Data), 64'(m_data));
        end
        check_val({ctx, ":count"},     64'(bus.o_Instr_Count), 64'(m_count));
        check_val({ctx, ":core_rstn"}, 64'(bus.o_Core_RSTN),   64'(m_mode == 2));
        check_val({ctx, ":load_done"}, 64'(bus.o_Load_Done),   64'(m_mode == 2));
        check_val({ctx, ":overflow"},  64'(bus.o_Overflow),    64'(m_ovf));
    endtask

    task automatic check_reset_values(input string ctx);
        check_val({ctx, ":rst_we"},    64'(bus.o_IMEM_WE),     64'd0);
        check_val({ctx, ":rst_addr"},  64'(bus.o_IMEM_Addr),   64'd0);
        check_val({ctx, ":rst_data"},  64'(bus.o_IMEM_Data),   64'd0);
        check_val({ctx, ":rst_core"},  64'(bus.o_Core_RSTN),   64'd0);
        check_val({ctx, ":rst_done"},  64'(bus.o_Load_Done),   64'd0);
        check_val({ctx, ":rst_count"}, 64'(bus.o_Instr_Count), 64'd0);
        check_val({ctx, ":rst_ovf"},   64'(bus.o_Overflow),    64'd0);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic send(input string ctx, input logic [31:0] w);
        bus.i_Write_Instr = w;
        @(posedge clk);
        model_step(w);
        @(negedge clk);
        check_outputs(ctx);
        $display("word 0x%08h %s: we=%0b addr=%0d cnt=%0d core_rstn=%0b ovf=%0b", w, ctx,
                 bus.o_IMEM_WE, bus.o_IMEM_Addr, bus.o_Instr_Count, bus.o_Core_RSTN, bus.o_Overflow);
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs checked before any clock edge.
    task automatic async_reset(input string ctx);
        #2 rst_n = 1'b0;
        #1 check_reset_values(ctx);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SW || w == EW) w = 32'h1234_5678;
        return w;
    endfunction

    function automatic logic [31:0] stray_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 5)  return SW;
        if (r < 10) return EW;
        if (r < 18) return 32'h0;
        return plain_word();
    endfunction

    initial begin
        logic [31:0] prog [4];
        int          len;
        prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h00; prog[3] = 32'h33;
        for (int i = 0; i < DEPTH; i++) model_written[i] = 0;
        bus.i_Write_Instr = '0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("power_on");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic program with a zero instruction
        send("basic_start", SW);
        for (int i = 0; i < 4; i++) send("basic_word", prog[i]);
        send("basic_end", EW);
        check_val("basic_final_count", 64'(bus.o_Instr_Count), 64'd4);
        send("run_idle_word", 32'h1234);

        // Words before any START are ignored
        async_reset("pre_idle");
        send("idle_55", 32'h55);
        send("idle_ff", EW);
        send("idle_00", 32'h0);

        // Overflow: 65 non-marker words
        send("ovf_start", SW);
        for (int i = 0; i < DEPTH + 1; i++) send("ovf_word", 32'h1000 + 32'(i));
        check_val("ovf_sticky", 64'(bus.o_Overflow), 64'd1);
        send("ovf_end_ignored", EW);
        send("ovf_start_ignored", SW);
        async_reset("ovf_exit");

        // Reload from RUN
        send("rl_start", SW);
        send("rl_w", 32'h01);
        send("rl_end", EW);
        send("rl_restart", SW);
        send("rl_aa", 32'hAA);
        send("rl_end2", EW);

        // Restart inside LOAD
        send("rs_start", SW);
        send("rs_11", 32'h11);
        send("rs_22", 32'h22);
        send("rs_restart", SW);
        send("rs_99", 32'h99);
        send("rs_end", EW);
        check_val("rs_count", 64'(bus.o_Instr_Count), 64'd1);

        // Empty program
        send("empty_start", SW);
        send("empty_end", EW);

        // Reset in the middle of loading
        send("mid_start", SW);
        for (int i = 0; i < 3; i++) send("mid_word", 32'h700 + 32'(i));
        async_reset("mid_load");
        send("mid_44", 32'h44);
        send("mid_ff", EW);

        // Randomized bursts of framed programs with stray markers and resets
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 9) == 0) async_reset("rnd_reset");
            send("rnd_start", SW);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 19) == 0) send("rnd_stray", stray_word());
                else send("rnd_word", plain_word());
            end
            send("rnd_end", EW);
            for (int i = 0; i < $urandom_range(0, 3); i++) send("rnd_junk", stray_word());
            if (m_mode == 3) async_reset("rnd_err_exit");
        end

        // Memory as seen by the write bus must match every word the model stored
        for (int i = 0; i < DEPTH; i++)
            if (model_written[i]) check_val($sformatf("mem[%0d]", i), 64'(shadow_mem[i]), 64'(model_mem[i]));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
